// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M/RV64M multiply/divide unit:
// funct3 op codes, FSM state type and operand-signedness helpers.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic a_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic b_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: LSB-first shift-add for multiply, restoring
// shift-subtract for divide. hi holds the partial product / remainder, lo the multiplier / quotient.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            div_mode,
    input  logic [XLEN-1:0] hi_in,
    input  logic [XLEN-1:0] lo_in,
    input  logic [XLEN-1:0] operand_b,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand_b} : {(XLEN+1){1'b0}});
        shifted = {hi_in, lo_in[XLEN-1]};
        diff    = shifted - {1'b0, operand_b};
        hi_out  = sum[XLEN:1];
        lo_out  = {sum[0], lo_in[XLEN-1:1]};
        if (div_mode) begin
            // Borrow out of the subtract means the trial divisor did not fit: restore.
            if (diff[XLEN]) begin
                hi_out = shifted[XLEN-1:0];
                lo_out = {lo_in[XLEN-2:0], 1'b0};
            end else begin
                hi_out = diff[XLEN-1:0];
                lo_out = {lo_in[XLEN-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative M-extension unit: operands are reduced to magnitudes at accept,
// processed STEP_BITS bits per cycle, then sign-corrected in FIX.
//   state | meaning
//   IDLE  | ready for a new op
//   CALC  | N shift-add / shift-subtract iterations
//   FIX   | sign correction and result select
//   DONE  | response held until resp_ready
module riscv_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int STEP_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic [4:0]      req_rd,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [4:0]      resp_rd,
    output logic            busy
);

    localparam int N  = XLEN / STEP_BITS;
    localparam int CW = $clog2(N) + 1;

    state_t state, state_nxt;

    logic [2:0]      op_q;
    logic [XLEN-1:0] hi_q, lo_q, b_q;
    logic            neg_q;
    logic [CW-1:0]   cnt_q;

    logic            accept, sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b, min_neg;

    logic [XLEN-1:0]   hi_c [0:STEP_BITS];
    logic [XLEN-1:0]   lo_c [0:STEP_BITS];
    logic [2*XLEN-1:0] prod_raw, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, result;

    assign req_ready = (state == ST_IDLE) && !rst;
    assign busy      = (state != ST_IDLE);
    assign accept    = req_valid && req_ready && !flush;

    always_comb begin
        min_neg  = {1'b1, {(XLEN-1){1'b0}}};
        sa       = a_signed(req_op) && req_a[XLEN-1];
        sb       = b_signed(req_op) && req_b[XLEN-1];
        mag_a    = sa ? (~req_a + 1'b1) : req_a;
        mag_b    = sb ? (~req_b + 1'b1) : req_b;
        div_zero = is_div(req_op) && (req_b == '0);
        div_ovf  = is_div(req_op) && b_signed(req_op) && (req_a == min_neg) && (req_b == '1);
    end

    assign hi_c[0] = hi_q;
    assign lo_c[0] = lo_q;

    for (genvar g = 0; g < STEP_BITS; g++) begin : g_step
        muldiv_step #(.XLEN(XLEN)) u_step (
            .div_mode  (is_div(op_q)),
            .hi_in     (hi_c[g]),
            .lo_in     (lo_c[g]),
            .operand_b (b_q),
            .hi_out    (hi_c[g+1]),
            .lo_out    (lo_c[g+1])
        );
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = (div_zero || div_ovf) ? ST_FIX : ST_CALC;
            ST_CALC: if (cnt_q == CW'(N - 1)) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: if (resp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (flush) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        prod_raw = {hi_q, lo_q};
        prod_fix = neg_q ? (~prod_raw + 1'b1) : prod_raw;
        quo_fix  = neg_q ? (~lo_q + 1'b1) : lo_q;
        rem_fix  = neg_q ? (~hi_q + 1'b1) : hi_q;
        case (op_q)
            OP_MUL:                       result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result = quo_fix;
            default:                      result = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            b_q        <= '0;
            neg_q      <= 1'b0;
            cnt_q      <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_rd    <= '0;
        end else begin
            if (accept) begin
                op_q    <= req_op;
                resp_rd <= req_rd;
                cnt_q   <= '0;
                // Special cases preload the final quotient/remainder with no sign fix-up.
                if (div_zero) begin
                    hi_q  <= req_a;
                    lo_q  <= '1;
                    neg_q <= 1'b0;
                end else if (div_ovf) begin
                    hi_q  <= '0;
                    lo_q  <= req_a;
                    neg_q <= 1'b0;
                end else begin
                    hi_q  <= '0;
                    lo_q  <= mag_a;
                    b_q   <= mag_b;
                    neg_q <= (req_op == OP_REM) ? sa : (sa ^ sb);
                end
            end else if (state == ST_CALC) begin
                hi_q  <= hi_c[STEP_BITS];
                lo_q  <= lo_c[STEP_BITS];
                cnt_q <= cnt_q + 1'b1;
            end
            resp_valid <= (state_nxt == ST_DONE);
            if (state == ST_FIX && !flush) resp_data <= result;
        end
    end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Scoreboard bench for two riscv_muldiv_unit instances (XLEN 32, STEP_BITS 1 and 4)
// against a plain-arithmetic RV32M reference model.
module tb_riscv_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        int          acc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst, req_valid, flush, resp_ready;
    logic [1:0][2:0]  req_op;
    logic [1:0][31:0] req_a, req_b;
    logic [1:0][4:0]  req_rd;
    wire  [1:0]       req_ready, resp_valid, busy;
    wire  [1:0][31:0] resp_data;
    wire  [1:0][4:0]  resp_rd;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rr_mode [2];
    bit   [1:0] seen;
    exp_t q0 [$];
    exp_t q1 [$];

    riscv_muldiv_unit #(.XLEN(32), .STEP_BITS(1)) u_dut_s1 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_op(req_op[0]), .req_a(req_a[0]), .req_b(req_b[0]), .req_rd(req_rd[0]),
        .flush(flush[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_data(resp_data[0]), .resp_rd(resp_rd[0]), .busy(busy[0])
    );

    riscv_muldiv_unit #(.XLEN(32), .STEP_BITS(4)) u_dut_s4 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_op(req_op[1]), .req_a(req_a[1]), .req_b(req_b[1]), .req_rd(req_rd[1]),
        .flush(flush[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_data(resp_data[1]), .resp_rd(resp_rd[1]), .busy(busy[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    // Reference model: 64-bit host arithmetic straight from the RV32M definitions.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa_l = longint'($signed(a));
        longint          sb_l = longint'($signed(b));
        longint unsigned ua   = {32'b0, a};
        longint unsigned ub   = {32'b0, b};
        logic [63:0]     p;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa_l * sb_l; return p[63:32]; end
            3'd2: begin p = sa_l * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = sa_l / sb_l;
                return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                p = sa_l % sb_l;
                return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit special;
        special = (op >= 3'd4) && ((b == 32'd0) ||
                  (((op == 3'd4) || (op == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
        if (special) return 2;
        return ((i == 0) ? 32 : 8) + 2;
    endfunction

    function automatic int q_size(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t q_front(input int i);
        if (i == 0) return q0[0];
        return q1[0];
    endfunction

    function automatic void q_pop(input int i);
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endfunction

    function automatic void q_push(input int i, input exp_t e);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    task automatic issue(input int i, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input bit push);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!req_ready[i] && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            chk("ready_timeout", 64'd0, 64'd1);
            return;
        end
        req_valid[i] = 1'b1;
        req_op[i]    = op;
        req_a[i]     = a;
        req_b[i]     = b;
        req_rd[i]    = rd;
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
        if (push) begin
            e.data = model(op, a, b);
            e.rd   = rd;
            e.acc  = cyc;
            e.lat  = exp_lat(i, op, a, b);
            q_push(i, e);
        end
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while ((q_size(i) != 0 || !req_ready[i]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    task automatic rand_run(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            issue(i, op, rand_opnd(), rand_opnd(), 5'($urandom_range(0, 31)), 1'b1);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                case (rr_mode[i])
                    0:       resp_ready[i] = 1'b1;
                    1:       resp_ready[i] = ($urandom_range(0, 2) != 0);
                    default: resp_ready[i] = 1'b0;
                endcase
            end
        end
    end

    task automatic mon(input int i);
        exp_t e;
        if (rst[i]) begin
            seen[i] = 1'b0;
            return;
        end
        chk("ready_vs_busy", req_ready[i], !busy[i]);
        if (q_size(i) != 0 && !seen[i]) chk("busy_inflight", busy[i], 1'b1);
        if (resp_valid[i]) begin
            if (q_size(i) == 0) begin
                chk("unexpected_resp", 64'd1, 64'd0);
            end else begin
                e = q_front(i);
                if (!seen[i]) begin
                    chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
                    seen[i] = 1'b1;
                end
                chk("resp_data", resp_data[i], e.data);
                chk("resp_rd", resp_rd[i], e.rd);
                if (resp_ready[i]) begin
                    q_pop(i);
                    seen[i] = 1'b0;
                end
            end
        end else if (seen[i]) begin
            chk("valid_held", 64'd0, 64'd1);
            seen[i] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst        = 2'b11;
        req_valid  = '0;
        flush      = '0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        req_rd     = '0;
        rr_mode[0] = 0;
        rr_mode[1] = 0;
        seen       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_resp_valid", resp_valid[i], 1'b0);
            chk("rst_resp_data", resp_data[i], 32'd0);
            chk("rst_resp_rd", resp_rd[i], 5'd0);
            chk("rst_busy", busy[i], 1'b0);
            chk("rst_req_ready", req_ready[i], 1'b0);
        end
        rst = 2'b00;
        @(negedge clk);
        chk("release_ready0", req_ready[0], 1'b1);
        chk("release_ready1", req_ready[1], 1'b1);

        issue(0, OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd9,  1'b1);
        issue(0, OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1,  1'b1);
        issue(0, OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  1'b1);
        issue(0, OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  1'b1);
        issue(0, OP_DIV,    32'hFFFF_FFF9,  32'd2,         5'd4,  1'b1);
        issue(0, OP_REM,    32'hFFFF_FFF9,  32'd2,         5'd5,  1'b1);
        issue(0, OP_DIVU,   32'd100,        32'd7,         5'd6,  1'b1);
        issue(0, OP_REMU,   32'd100,        32'd7,         5'd7,  1'b1);
        issue(0, OP_DIVU,   32'd5,          32'd0,         5'd8,  1'b1);
        issue(0, OP_REM,    32'd5,          32'd0,         5'd10, 1'b1);
        issue(0, OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 1'b1);
        issue(0, OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 1'b1);
        wait_idle(0);

        issue(0, OP_MUL, $urandom(), $urandom(), 5'd13, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush[0] = 1'b1;
        @(posedge clk);
        #1;
        flush[0] = 1'b0;
        @(negedge clk);
        chk("flush_resp_valid", resp_valid[0], 1'b0);
        chk("flush_busy", busy[0], 1'b0);
        chk("flush_req_ready", req_ready[0], 1'b1);
        repeat (40) @(negedge clk);
        flush[0]     = 1'b1;
        req_valid[0] = 1'b1;
        req_op[0]    = OP_MUL;
        req_a[0]     = 32'd5;
        req_b[0]     = 32'd5;
        @(posedge clk);
        #1;
        flush[0]     = 1'b0;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("flush_beats_accept", busy[0], 1'b0);
        issue(0, OP_MUL, 32'd3, 32'd4, 5'd14, 1'b1);
        wait_idle(0);

        issue(1, OP_MUL, 32'd3, 32'd4, 5'd15, 1'b1);
        wait_idle(1);
        rr_mode[1] = 2;
        issue(1, OP_MUL, 32'd3, 32'd4, 5'd17, 1'b1);
        n = 0;
        while (!resp_valid[1] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("stall_resp_timeout", 64'd0, 64'd1);
        repeat (5) @(negedge clk);
        rr_mode[1] = 0;
        wait_idle(1);

        issue(1, OP_MUL, 32'd9, 32'd9, 5'd21, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        chk("midrst_resp_valid", resp_valid[1], 1'b0);
        chk("midrst_resp_data", resp_data[1], 32'd0);
        chk("midrst_resp_rd", resp_rd[1], 5'd0);
        chk("midrst_busy", busy[1], 1'b0);
        chk("midrst_req_ready", req_ready[1], 1'b0);
        rst[1] = 1'b0;
        @(negedge clk);
        chk("midrst_release_ready", req_ready[1], 1'b1);

        rr_mode[0] = 1;
        rr_mode[1] = 1;
        fork
            rand_run(0, 30);
            rand_run(1, 60);
        join
        rr_mode[0] = 0;
        rr_mode[1] = 0;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("drain_timeout", 64'd0, 64'd1);
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
